zw_classifier: RTL and testbench

Sequential consumer placed directly downstream of the two-input combinational stage that produces `z = x AND y` and `w = x OR y`. Each clock on which `valid` is high, it samples the `{z, w}` pair and classifies it as none (00), exactly-one (01) or both (11). It keeps a saturating counter per class, raises a sticky error on the impossible code 10, and emits a one-cycle `match` pulse when a 01 sample is immediately followed by an 11 sample.

---
 rtl/zw_pkg.sv | 14 +
 rtl/zw_classifier_sat_counter.sv | 21 ++
 rtl/zw_classifier.sv | 76 +++++++
 tb/tb_zw_classifier.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/zw_pkg.sv
// Shared code constants and FSM encoding for the z/w sample classifier.
package zw_pkg;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_ONE     = 2'b01;
    localparam logic [1:0] CODE_BOTH    = 2'b11;
    localparam logic [1:0] CODE_ILLEGAL = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

endpackage

// File: rtl/zw_classifier_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/zw_classifier.sv
// Classifies {z,w} samples into none/one/both, counts them, flags the
// impossible 10 code and pulses match on a 01 -> 11 accepted pair.
module zw_classifier
    import zw_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid,
    input  logic         z,
    input  logic         w,
    input  logic         clear,
    output logic [W-1:0] cnt_none,
    output logic [W-1:0] cnt_one,
    output logic [W-1:0] cnt_both,
    output logic         match,
    output logic         error
);

    logic [1:0] code;
    logic       accept;
    state_t     state, state_nx;
    logic       match_nx;

    assign code   = {z, w};
    assign accept = valid && !clear;

    sat_counter #(.W(W)) u_none (
        .clock(clock), .reset(reset), .clear(clear),
        .inc(accept && (code == CODE_NONE)), .count(cnt_none)
    );

    sat_counter #(.W(W)) u_one (
        .clock(clock), .reset(reset), .clear(clear),
        .inc(accept && (code == CODE_ONE)), .count(cnt_one)
    );

    sat_counter #(.W(W)) u_both (
        .clock(clock), .reset(reset), .clear(clear),
        .inc(accept && (code == CODE_BOTH)), .count(cnt_both)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // Idle cycles hold the state so a gap does not break a 01 -> 11 pair.
    always_comb begin
        state_nx = state;
        match_nx = 1'b0;
        if (clear) begin
            state_nx = IDLE;
        end else if (valid) begin
            match_nx = (state == ARMED) && (code == CODE_BOTH);
            state_nx = (code == CODE_ONE) ? ARMED : IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            match <= 1'b0;
            error <= 1'b0;
        end else begin
            match <= match_nx;
            if (clear)
                error <= 1'b0;
            else if (accept && (code == CODE_ILLEGAL))
                error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_zw_classifier.sv
// Randomized and directed check of zw_classifier against a sample-history model.
module tb_zw_classifier;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic valid = 1'b0;
    logic z     = 1'b0;
    logic w     = 1'b0;
    logic clear = 1'b0;

    logic [7:0] cnt_none, cnt_one, cnt_both;
    logic       match, error;
    logic [1:0] s_none, s_one, s_both;
    logic       s_match, s_error;

    int asserts = 0;
    int fails   = 0;

    // model: raw class counts since last clear, last accepted code (-1 = none)
    int n_none = 0, n_one = 0, n_both = 0, last = -1;
    bit e_err = 0, e_match = 0;

    zw_classifier #(.W(8)) dut (
        .clock(clock), .reset(reset), .valid(valid), .z(z), .w(w), .clear(clear),
        .cnt_none(cnt_none), .cnt_one(cnt_one), .cnt_both(cnt_both),
        .match(match), .error(error)
    );

    zw_classifier #(.W(2)) dut2 (
        .clock(clock), .reset(reset), .valid(valid), .z(z), .w(w), .clear(clear),
        .cnt_none(s_none), .cnt_one(s_one), .cnt_both(s_both),
        .match(s_match), .error(s_error)
    );

    always #5 clock = ~clock;

    function automatic int sat(int n, int wd);
        int mx;
        mx = (1 << wd) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        int code;
        if (reset) begin
            n_none = 0; n_one = 0; n_both = 0; last = -1;
            e_err = 0; e_match = 0;
        end else begin
            e_match = 0;
            if (clear) begin
                n_none = 0; n_one = 0; n_both = 0; last = -1; e_err = 0;
            end else if (valid) begin
                code = {30'd0, z, w};
                if (code == 0) n_none++;
                else if (code == 1) n_one++;
                else if (code == 3) n_both++;
                else e_err = 1;
                e_match = (last == 1) && (code == 3);
                last = code;
            end
        end
    end

    always @(negedge clock) begin
        chk("cnt_none",  cnt_none, sat(n_none, 8));
        chk("cnt_one",   cnt_one,  sat(n_one, 8));
        chk("cnt_both",  cnt_both, sat(n_both, 8));
        chk("match",     match,    e_match);
        chk("error",     error,    e_err);
        chk("w2_none",   s_none,   sat(n_none, 2));
        chk("w2_one",    s_one,    sat(n_one, 2));
        chk("w2_both",   s_both,   sat(n_both, 2));
        chk("w2_match",  s_match,  e_match);
        chk("w2_error",  s_error,  e_err);
    end

    task automatic drive(bit v, bit c, logic [1:0] code);
        valid = v; clear = c; z = code[1]; w = code[0];
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic put(logic [1:0] code);
        drive(1, 0, code);
        tick();
    endtask

    initial begin
        tick(); tick();
        chk("rst_none", cnt_none, 0);
        chk("rst_both", cnt_both, 0);
        chk("rst_match", match, 0);
        chk("rst_error", error, 0);
        reset = 1'b0;

        put(2'b00); put(2'b01); put(2'b11);
        chk("t1_none", cnt_none, 1);
        chk("t1_one", cnt_one, 1);
        chk("t1_both", cnt_both, 1);
        chk("t1_match", match, 1);
        chk("t1_error", error, 0);
        drive(0, 0, 2'b00); tick();
        chk("t1_match_drop", match, 0);

        put(2'b10);
        chk("t2_error", error, 1);
        chk("t2_none", cnt_none, 1);
        chk("t2_both", cnt_both, 1);
        put(2'b00);
        chk("t2_error_sticky", error, 1);
        chk("t2_none_inc", cnt_none, 2);

        put(2'b01);
        drive(1, 1, 2'b01); tick();
        chk("clr_one", cnt_one, 0);
        chk("clr_none", cnt_none, 0);
        chk("clr_error", error, 0);
        put(2'b11);
        chk("clr_no_match", match, 0);

        drive(0, 1, 2'b00); tick();
        repeat (6) put(2'b11);
        chk("sat_w2_both", s_both, 3);
        chk("sat_w2_one", s_one, 0);
        chk("sat_w8_both", cnt_both, 6);

        put(2'b01);
        drive(0, 0, 2'b11); tick(); tick(); tick();
        chk("gap_no_early", match, 0);
        put(2'b11);
        chk("gap_match", match, 1);
        drive(0, 0, 2'b00); tick();
        chk("gap_single", match, 0);

        put(2'b01); put(2'b00); put(2'b11);
        chk("break_no_match", match, 0);

        put(2'b01); chk("b2b_c1", match, 0);
        put(2'b11); chk("b2b_c2", match, 1);
        put(2'b01); chk("b2b_c3", match, 0);
        put(2'b11); chk("b2b_c4", match, 1);

        put(2'b01); put(2'b01);
        chk("rearm_no", match, 0);
        put(2'b11);
        chk("rearm_match", match, 1);
        put(2'b11);
        chk("rearm_once", match, 0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
                  2'($urandom_range(0, 3)));
            tick();
        end

        put(2'b00); put(2'b01);
        drive(1, 0, 2'b11);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk("arst_none", cnt_none, 0);
        chk("arst_one", cnt_one, 0);
        chk("arst_both", cnt_both, 0);
        chk("arst_match", match, 0);
        chk("arst_error", error, 0);
        chk("arst_w2_both", s_both, 0);
        drive(0, 0, 2'b00);
        tick();
        reset = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
